// File: rtl/sequencer_pkg.sv
// sequencer_pkg: opcodes, state encodings and instruction decode for insn_sequencer
package sequencer_pkg;
   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_HALT  = 4'd1;
   localparam logic [3:0] OP_INC   = 4'd2;
   localparam logic [3:0] OP_DEC   = 4'd3;
   localparam logic [3:0] OP_RIGHT = 4'd4;
   localparam logic [3:0] OP_LEFT  = 4'd5;
   localparam logic [3:0] OP_JZ    = 4'd6;
   localparam logic [3:0] OP_JNZ   = 4'd7;
   localparam logic [3:0] OP_OUT   = 4'd8;
   localparam logic [3:0] OP_IN    = 4'd9;

   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_DATA = 2'd1;
   localparam logic [1:0] SEL_AP   = 2'd2;
   localparam logic [1:0] SEL_IO   = 2'd3;

   typedef enum logic [6:0] {
      S_IDLE      = 7'b0000001,
      S_DECODE    = 7'b0000010,
      S_EXEC_REQ  = 7'b0000100,
      S_EXEC_WAIT = 7'b0001000,
      S_ADV_REQ   = 7'b0010000,
      S_ADV_WAIT  = 7'b0100000,
      S_HALT      = 7'b1000000
   } state_e;

   typedef enum logic [1:0] {HS_IDLE, HS_WAIT_LO, HS_WAIT_HI} hs_state_e;

   // {servant_sel, dec}; for SEL_IO the dec bit selects input (1) over output (0)
   function automatic logic [2:0] decode_op(input logic [3:0] op);
      case (op)
         OP_INC:   decode_op = {SEL_DATA, 1'b0};
         OP_DEC:   decode_op = {SEL_DATA, 1'b1};
         OP_RIGHT: decode_op = {SEL_AP, 1'b0};
         OP_LEFT:  decode_op = {SEL_AP, 1'b1};
         OP_OUT:   decode_op = {SEL_IO, 1'b0};
         OP_IN:    decode_op = {SEL_IO, 1'b1};
         default:  decode_op = {SEL_NONE, 1'b0};
      endcase
   endfunction
endpackage

// File: rtl/req_handshake.sv
// req_handshake: generic four-phase requester (req up, ready low, ready high, req down)
module req_handshake
   import sequencer_pkg::*;
(
   input  logic Clk,
   input  logic Rst_n,
   input  logic start,
   input  logic ready,
   output logic req,
   output logic done
);
   hs_state_e hs, hs_nx;

   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) hs <= HS_IDLE;
      else hs <= hs_nx;

   always_comb begin
      hs_nx = hs;
      case (hs)
         HS_IDLE:    hs_nx = start ? HS_WAIT_LO : HS_IDLE;
         HS_WAIT_LO: hs_nx = ready ? HS_WAIT_LO : HS_WAIT_HI;
         HS_WAIT_HI: hs_nx = ready ? HS_IDLE : HS_WAIT_HI;
         default:    hs_nx = HS_IDLE;
      endcase
   end

   assign req  = hs != HS_IDLE;
   assign done = hs == HS_WAIT_HI && ready;
endmodule

// File: rtl/insn_sequencer.sv
// insn_sequencer: fetch/decode/dispatch controller for the dekatron machine
module insn_sequencer
   import sequencer_pkg::*;
#(
   parameter int INSN_WIDTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Run,
   input  logic                  Step,
   input  logic [INSN_WIDTH-1:0] Insn,
   output logic                  IpRequest,
   input  logic                  IpReady,
   output logic                  DataIsZeroed,
   output logic                  ApRequest,
   output logic                  ApDec,
   input  logic                  ApReady,
   output logic                  DataRequest,
   output logic                  DataDec,
   input  logic                  DataReady,
   input  logic                  DataZero,
   output logic                  IoOutRequest,
   input  logic                  IoOutReady,
   output logic                  IoInRequest,
   input  logic                  IoInReady,
   output logic                  Halted,
   output logic                  Busy,
   output logic [CNT_WIDTH-1:0]  RetiredCount
);
   state_e state, state_nx;
   logic [1:0] sel_q;
   logic dec_q, zeroed_q;
   logic [CNT_WIDTH-1:0] retired_q;
   logic [3:0] op;
   logic [2:0] dcd;
   logic hs_start, hs_req, hs_done, hs_ready;

   assign op  = 4'(Insn);
   assign dcd = decode_op(op);
   assign hs_start = state == S_DECODE && dcd[2:1] != SEL_NONE;
   assign hs_ready = sel_q == SEL_DATA ? DataReady :
                     sel_q == SEL_AP   ? ApReady :
                     sel_q == SEL_IO   ? (dec_q ? IoInReady : IoOutReady) : 1'b1;

   req_handshake u_hs (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .start (hs_start),
      .ready (hs_ready),
      .req   (hs_req),
      .done  (hs_done)
   );

   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         state     <= S_IDLE;
         sel_q     <= SEL_NONE;
         dec_q     <= 1'b0;
         zeroed_q  <= 1'b1;
         retired_q <= '0;
      end else begin
         state <= state_nx;
         if (state == S_DECODE) begin
            sel_q <= dcd[2:1];
            dec_q <= dcd[0];
         end
         // '+', '-' and ',' all leave a fresh value in the data counter
         if (state == S_EXEC_WAIT && hs_done && (sel_q == SEL_DATA || (sel_q == SEL_IO && dec_q)))
            zeroed_q <= DataZero;
         if (state == S_ADV_WAIT && IpReady)
            retired_q <= retired_q + 1'b1;
      end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:      state_nx = (Run || Step) ? S_DECODE : S_IDLE;
         S_DECODE:    state_nx = op == OP_HALT ? S_HALT :
                                 dcd[2:1] != SEL_NONE ? S_EXEC_REQ : S_ADV_REQ;
         S_EXEC_REQ:  state_nx = hs_ready ? S_EXEC_REQ : S_EXEC_WAIT;
         S_EXEC_WAIT: state_nx = hs_done ? S_ADV_REQ : S_EXEC_WAIT;
         S_ADV_REQ:   state_nx = IpReady ? S_ADV_REQ : S_ADV_WAIT;
         S_ADV_WAIT:  state_nx = !IpReady ? S_ADV_WAIT : Run ? S_DECODE : S_IDLE;
         S_HALT:      state_nx = S_HALT;
         default:     state_nx = S_IDLE;
      endcase
   end

   assign IpRequest    = state == S_ADV_REQ || state == S_ADV_WAIT;
   assign DataRequest  = hs_req && sel_q == SEL_DATA;
   assign DataDec      = sel_q == SEL_DATA && dec_q;
   assign ApRequest    = hs_req && sel_q == SEL_AP;
   assign ApDec        = sel_q == SEL_AP && dec_q;
   assign IoOutRequest = hs_req && sel_q == SEL_IO && !dec_q;
   assign IoInRequest  = hs_req && sel_q == SEL_IO && dec_q;
   assign DataIsZeroed = zeroed_q;
   assign Halted       = state == S_HALT;
   assign Busy         = state != S_IDLE && state != S_HALT;
   assign RetiredCount = retired_q;
endmodule

// File: tb/tb_insn_sequencer.sv
// tb_insn_sequencer: directed scenarios against modelled IP line and servants
module tb_insn_sequencer;
   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   logic Run = 1'b0;
   logic Step = 1'b0;
   logic [3:0] Insn = 4'd0;
   logic IpRequest, DataIsZeroed, ApRequest, ApDec, DataRequest, DataDec;
   logic IoOutRequest, IoInRequest, Halted, Busy;
   logic [15:0] RetiredCount;
   logic [4:0] rdy = 5'b11111;
   logic DataZero = 1'b0;
   logic [4:0] rq, rq_prev = 5'b0;

   int checks = 0;
   int errors = 0;
   int ncnt[5];
   int ph[5];
   int cd[5];
   int dly = 0;
   int zero_at = 0;
   int pc = 0;
   logic [31:0] prog_w = 32'h0;
   logic [7:0] dlog, alog, iplog;
   logic dz_hold, dz_bad, ovl;

   always #5 Clk = ~Clk;

   insn_sequencer dut (
      .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step), .Insn(Insn),
      .IpRequest(IpRequest), .IpReady(rdy[0]), .DataIsZeroed(DataIsZeroed),
      .ApRequest(ApRequest), .ApDec(ApDec), .ApReady(rdy[1]),
      .DataRequest(DataRequest), .DataDec(DataDec), .DataReady(rdy[2]), .DataZero(DataZero),
      .IoOutRequest(IoOutRequest), .IoOutReady(rdy[3]),
      .IoInRequest(IoInRequest), .IoInReady(rdy[4]),
      .Halted(Halted), .Busy(Busy), .RetiredCount(RetiredCount)
   );

   assign rq = {IoInRequest, IoOutRequest, DataRequest, ApRequest, IpRequest};

   // monitor first, then servant and IP-line models, all on the falling edge
   always @(negedge Clk) begin
      for (int i = 0; i < 5; i++)
         if (rq[i] && !rq_prev[i]) ncnt[i]++;
      if (DataRequest && !rq_prev[2]) begin
         dlog = {dlog[6:0], DataDec};
         DataZero = (ncnt[2] == zero_at);
      end
      if (ApRequest && !rq_prev[1]) alog = {alog[6:0], ApDec};
      if (IpRequest && !rq_prev[0]) begin
         iplog = {iplog[6:0], DataIsZeroed};
         dz_hold = DataIsZeroed;
      end
      if (IpRequest && rq_prev[0] && DataIsZeroed !== dz_hold) dz_bad = 1'b1;
      if ($countones(rq) > 1) ovl = 1'b1;
      rq_prev = rq;
      for (int i = 0; i < 5; i++) begin
         if (!Rst_n) begin
            ph[i] = 0;
            rdy[i] = 1'b1;
         end else case (ph[i])
            0: if (rq[i]) begin cd[i] = dly; ph[i] = 1; end
            1: if (cd[i] == 0) begin rdy[i] = 1'b0; cd[i] = dly; ph[i] = 2; end else cd[i]--;
            2: if (cd[i] == 0) begin
                  rdy[i] = 1'b1;
                  ph[i] = 3;
                  if (i == 0) begin
                     pc++;
                     Insn = prog_w[4*pc +: 4];
                  end
               end else cd[i]--;
            default: if (!rq[i]) ph[i] = 0;
         endcase
      end
   end

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   task automatic clr();
      for (int i = 0; i < 5; i++) ncnt[i] = 0;
      dlog = '0; alog = '0; iplog = '0;
      dz_bad = 1'b0; ovl = 1'b0;
   endtask

   task automatic do_reset(input logic [31:0] p, input int d, input int za);
      Rst_n = 1'b0; Run = 1'b0; Step = 1'b0;
      tick(); tick();
      prog_w = p; dly = d; zero_at = za; pc = 0;
      Insn = p[3:0]; DataZero = 1'b0;
      clr();
      Rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_idle(input string nm);
      int c;
      for (c = 0; c < 400 && Busy; c++) tick();
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL %s timeout: Busy=%b want 0", nm, Busy); end
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      tick(); tick();
      checks++; if (rq !== 5'b0) begin errors++; $display("FAIL reset_req: got %b want 00000", rq); end
      checks++; if ({ApDec, DataDec} !== 2'b00) begin errors++; $display("FAIL reset_dec: got %b want 00", {ApDec, DataDec}); end
      checks++; if (DataIsZeroed !== 1'b1) begin errors++; $display("FAIL reset_dz: got %b want 1", DataIsZeroed); end
      checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", Halted); end
      checks++; if (RetiredCount !== 16'd0) begin errors++; $display("FAIL reset_retired: got %0d want 0", RetiredCount); end
      do_reset(32'h0000_0000, 0, 0);
      tick(); tick(); tick();
      checks++; if (Busy !== 1'b0 || rq !== 5'b0) begin errors++; $display("FAIL idle_hold: Busy=%b req=%b want 0 00000", Busy, rq); end
   endtask

   task automatic test_free_run();
      int c;
      int ipn;
      do_reset(32'h0001_8322, 3, 0);
      Run = 1'b1;
      for (c = 0; c < 1000 && !Halted; c++) tick();
      checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL run_halted: got %b want 1", Halted); end
      checks++; if (ncnt[2] != 3) begin errors++; $display("FAIL run_data_reqs: got %0d want 3", ncnt[2]); end
      checks++; if (dlog[2:0] !== 3'b001) begin errors++; $display("FAIL run_data_dec: got %b want 001", dlog[2:0]); end
      checks++; if (ncnt[3] != 1 || ncnt[1] != 0 || ncnt[4] != 0) begin errors++; $display("FAIL run_io_ap: out=%0d ap=%0d in=%0d want 1 0 0", ncnt[3], ncnt[1], ncnt[4]); end
      checks++; if (RetiredCount !== 16'd4) begin errors++; $display("FAIL run_retired: got %0d want 4", RetiredCount); end
      checks++; if (ovl !== 1'b0) begin errors++; $display("FAIL run_overlap: got %b want 0", ovl); end
      ipn = ncnt[0];
      Step = 1'b1; tick(); Step = 1'b0;
      for (int k = 0; k < 10; k++) tick();
      checks++; if (Halted !== 1'b1 || Busy !== 1'b0 || ncnt[0] != ipn) begin errors++; $display("FAIL halt_sticky: Halted=%b Busy=%b ip=%0d want 1 0 %0d", Halted, Busy, ncnt[0], ipn); end
   endtask

   task automatic test_step();
      do_reset(32'h0000_0154, 1, 0);
      Step = 1'b1; tick(); Step = 1'b0;
      wait_idle("step1");
      for (int k = 0; k < 8; k++) tick();
      checks++; if (ncnt[1] != 1 || alog[0] !== 1'b0) begin errors++; $display("FAIL step1_ap: n=%0d dec=%b want 1 0", ncnt[1], alog[0]); end
      checks++; if (RetiredCount !== 16'd1 || Busy !== 1'b0) begin errors++; $display("FAIL step1_idle: retired=%0d Busy=%b want 1 0", RetiredCount, Busy); end
      Step = 1'b1; tick(); Step = 1'b0;
      wait_idle("step2");
      checks++; if (ncnt[1] != 2 || alog[1:0] !== 2'b01) begin errors++; $display("FAIL step2_ap: n=%0d dec=%b want 2 01", ncnt[1], alog[1:0]); end
      checks++; if (RetiredCount !== 16'd2 || Halted !== 1'b0) begin errors++; $display("FAIL step2_retired: retired=%0d Halted=%b want 2 0", RetiredCount, Halted); end
   endtask

   task automatic test_zero_flag();
      int c;
      do_reset(32'h0000_1732, 1, 2);
      Run = 1'b1;
      for (c = 0; c < 500 && !Halted; c++) tick();
      checks++; if (Halted !== 1'b1 || ncnt[0] != 3) begin errors++; $display("FAIL zero_run: Halted=%b ip=%0d want 1 3", Halted, ncnt[0]); end
      checks++; if (iplog[2:0] !== 3'b011) begin errors++; $display("FAIL zero_flag_seq: got %b want 011", iplog[2:0]); end
      checks++; if (dz_bad !== 1'b0) begin errors++; $display("FAIL zero_flag_stable: got %b want 0", dz_bad); end
      checks++; if (ovl !== 1'b0) begin errors++; $display("FAIL zero_overlap: got %b want 0", ovl); end
   endtask

   task automatic test_run_drop();
      int c;
      do_reset(32'h0000_0122, 3, 0);
      Run = 1'b1;
      for (c = 0; c < 200 && !(DataRequest && !rdy[2]); c++) tick();
      tick();
      Run = 1'b0;
      wait_idle("run_drop");
      checks++; if (RetiredCount !== 16'd1 || ncnt[0] != 1) begin errors++; $display("FAIL drop_complete: retired=%0d ip=%0d want 1 1", RetiredCount, ncnt[0]); end
      for (int k = 0; k < 30; k++) tick();
      checks++; if (ncnt[2] != 1 || ncnt[0] != 1 || Busy !== 1'b0) begin errors++; $display("FAIL drop_quiet: data=%0d ip=%0d Busy=%b want 1 1 0", ncnt[2], ncnt[0], Busy); end
   endtask

   task automatic test_step_busy();
      do_reset(32'h0000_0188, 3, 0);
      Step = 1'b1; tick(); Step = 1'b0;
      tick(); tick(); tick();
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL busy_pulse1: Busy=%b want 1", Busy); end
      Step = 1'b1; tick(); Step = 1'b0;
      tick(); tick();
      Step = 1'b1; tick(); Step = 1'b0;
      wait_idle("step_busy");
      for (int k = 0; k < 10; k++) tick();
      checks++; if (ncnt[3] != 1 || RetiredCount !== 16'd1) begin errors++; $display("FAIL busy_ignored: out=%0d retired=%0d want 1 1", ncnt[3], RetiredCount); end
   endtask

   task automatic test_reset_mid();
      int c;
      do_reset(32'h0000_1002, 3, 0);
      Run = 1'b1;
      for (c = 0; c < 300 && !(RetiredCount == 16'd1 && IpRequest && !rdy[0]); c++) tick();
      tick();
      checks++; if (!(IpRequest && !rdy[0]) || DataIsZeroed !== 1'b0) begin errors++; $display("FAIL mid_setup: ipreq=%b ipready=%b dz=%b want 1 0 0", IpRequest, rdy[0], DataIsZeroed); end
      Rst_n = 1'b0;
      #1;
      checks++; if (rq !== 5'b0 || RetiredCount !== 16'd0) begin errors++; $display("FAIL mid_abort: req=%b retired=%0d want 00000 0", rq, RetiredCount); end
      checks++; if (DataIsZeroed !== 1'b1 || Halted !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL mid_flags: dz=%b Halted=%b Busy=%b want 1 0 0", DataIsZeroed, Halted, Busy); end
      Run = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_step();
      test_zero_flag();
      test_run_drop();
      test_step_busy();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/insn_sequencer.md
Name: insn_sequencer

Overview:
- Top-level execution controller for the Brainfuck-style dekatron machine.
- Drives the IP line through its Request/Ready handshake and decodes the 4-bit instruction it presents.
- Dispatches each instruction to the AP counter, the data counter or the I/O port, and supplies the latched data-zero flag the IP line uses for loop decisions.
- Supports free-run and single-step operation and a sticky HALT.

Parameters:
- INSN_WIDTH, 4, instruction width, must match the IP line.
- CNT_WIDTH, 16, width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- Run  in  1  level; 1 = free-run
- Step  in  1  one-cycle pulse; executes one instruction when Run=0
- Insn  in  INSN_WIDTH  current instruction from the IP line
- IpRequest  out  1  advance request to the IP line
- IpReady  in  1  IP line ready
- DataIsZeroed  out  1  latched data-zero flag to the IP line
- ApRequest  out  1  AP counter request
- ApDec  out  1  AP direction, 1 = decrement
- ApReady  in  1  AP counter ready
- DataRequest  out  1  data counter request
- DataDec  out  1  data direction, 1 = decrement
- DataReady  in  1  data counter ready
- DataZero  in  1  data counter value == 0 (valid while DataReady)
- IoOutRequest  out  1  '.' output request
- IoOutReady  in  1  output port ready
- IoInRequest  out  1  ',' input request
- IoInReady  in  1  input port ready
- Halted  out  1  sticky HALT reached
- Busy  out  1  state != IDLE and != HALT
- RetiredCount  out  CNT_WIDTH  instructions retired since reset, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset: all Request/Dec outputs 0, DataIsZeroed=1, Halted=0, RetiredCount=0, state IDLE. Reset asserted mid-handshake aborts immediately; servants recover through their own resets.
- Handshake with every servant is four-phase:
  - Assert Req; wait for Ready=0 (accepted); wait for Ready=1 (done); drop Req.
  - Dec is held stable from Req assertion until Req drops.
  - At most one Req is high at any time.
  - At least one cycle with Req low separates consecutive requests to the same servant.
- Instruction decode (values 10-15 decode as NOP):
  - 0 NOP
  - 1 HALT
  - 2 '+' data increment
  - 3 '-' data decrement
  - 4 '>' AP increment
  - 5 '<' AP decrement
  - 6 '[' no servant; flow is handled by the IP line
  - 7 ']' no servant; flow is handled by the IP line
  - 8 '.' output
  - 9 ',' input
- States:
  - IDLE: go to DECODE if Run=1, or if Step=1 on that cycle. Step pulses arriving while not in IDLE are ignored.
  - DECODE (1 cycle): HALT -> HALT. Data/AP/IO insns -> EXEC_REQ, raising the matching Req and Dec. NOP, '[', ']' -> ADV_REQ.
  - EXEC_REQ: wait for the servant's Ready=0, then -> EXEC_WAIT.
  - EXEC_WAIT: on Ready=1, drop Req. For '+', '-' or ',', latch DataIsZeroed<=DataZero on the same cycle. -> ADV_REQ.
  - ADV_REQ: IpRequest=1; on IpReady=0 -> ADV_WAIT.
  - ADV_WAIT: on IpReady=1, IpRequest=0 and RetiredCount+1. -> DECODE if Run=1, else IDLE.
  - HALT: Halted=1. All Req stay 0. Only Rst_n exits this state. Run and Step are ignored.
- DataIsZeroed:
  - Changes only in EXEC_WAIT, as above.
  - Stable throughout ADV_REQ/ADV_WAIT, so the IP line's loop lookup sees a constant flag.
- Run dropping mid-instruction: the current instruction completes, including the advance, then the block goes to IDLE.
- Insn is sampled only in DECODE; it must be stable from IpReady=1 through DECODE.
- Latency, zero-latency servants: NOP = DECODE+ADV_REQ+ADV_WAIT = 3 cycles; a servant insn = 5 cycles minimum.

Decomposition:
- Package sequencer_pkg:
  - Opcode localparams OP_NOP..OP_IN.
  - One-hot state encoding.
  - A decode function returning {servant_sel[1:0], dec}.
- Sub-module req_handshake: a generic four-phase requester with start, req, ready and done. Instantiate it once, with the servant's Ready muxed in by servant_sel.

Test Plan:
- Reset, then Run=1 with servants modelled at 3-cycle delay and program "+ + - ." then HALT -> exactly 3 DataRequests with DataDec pattern 0,0,1; 1 IoOutRequest; Halted=1; RetiredCount=4.
- Run=0 with two Step pulses on a '>' '<' program -> one ApRequest per pulse, ApDec 0 then 1; IDLE between pulses; RetiredCount=2.
- '-' with DataZero=1 at DataReady, then ']' -> DataIsZeroed=1, held constant for the whole IpRequest window; IpRequest is never high concurrently with DataRequest.
- Run dropped during EXEC_WAIT of '+' -> the instruction completes, the advance completes, then IDLE; no further requests follow.
- Step pulse while Busy=1 -> ignored; the request count is unchanged.
- Rst_n asserted during ADV_WAIT -> all Req=0 and RetiredCount=0 immediately; DataIsZeroed=1; Halted=0.
